// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data memory responder.
//   - MAX_LENGTH : default data word width
//   - size_e     : access size encodings carried on req_size
//   - state_e    : responder FSM states
//   - lane_enable / is_misaligned : byte-lane helpers for a 32-bit word
package data_mem_responder_pkg;

    localparam int MAX_LENGTH = 32;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_ILL  = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } state_e;

    // Little-endian byte lanes touched by an access.
    function automatic logic [3:0] lane_enable(input logic [1:0] size, input logic [1:0] addr_lo);
        logic [3:0] be;
        case (size)
            SIZE_BYTE: be = 4'b0001 << addr_lo;
            SIZE_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
            SIZE_WORD: be = 4'b1111;
            default:   be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        return ((size == SIZE_HALF) && addr_lo[0]) ||
               ((size == SIZE_WORD) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/data_mem_responder_load_align.sv
// Load alignment: picks the addressed byte/half/word out of a memory word
// and sign- or zero-extends it to DATA_WIDTH.
//   word     : full memory word read from the array
//   addr_lo  : byte offset within the word
//   size     : access size (byte/half/word; illegal gives 0)
//   sign_ext : 1 = sign-extend, 0 = zero-extend (ignored for words)
//   data     : extended, right-justified result
module load_align
    import data_mem_responder_pkg::*;
#(
    parameter int DATA_WIDTH = MAX_LENGTH
) (
    input  logic [DATA_WIDTH-1:0] word,
    input  logic [1:0]            addr_lo,
    input  logic [1:0]            size,
    input  logic                  sign_ext,
    output logic [DATA_WIDTH-1:0] data
);

    logic [7:0]  byte_f;
    logic [15:0] half_f;

    always_comb begin
        byte_f = word[{addr_lo, 3'b000} +: 8];
        half_f = addr_lo[1] ? word[16 +: 16] : word[0 +: 16];
        data   = '0;
        case (size)
            SIZE_BYTE: data = sign_ext ? {{(DATA_WIDTH-8){byte_f[7]}}, byte_f}
                                       : {{(DATA_WIDTH-8){1'b0}}, byte_f};
            SIZE_HALF: data = sign_ext ? {{(DATA_WIDTH-16){half_f[15]}}, half_f}
                                       : {{(DATA_WIDTH-16){1'b0}}, half_f};
            SIZE_WORD: data = word;
            default:   data = '0;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the processor load/store port.
// One request at a time: accept in IDLE, sit WAIT_CYCLES in WAIT, then
// commit the access on the edge entering RESP and hold the response until
// the consumer takes it.
//   clk, reset (async, active-low)
//   req_valid/req_ready          : request handshake
//   req_write/size/signed/addr/wdata : request fields (byte address)
//   resp_valid/resp_ready        : response handshake
//   resp_rdata                   : load result (0 for stores and errors)
//   resp_error                   : misaligned, illegal size or out of range
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int DATA_WIDTH  = MAX_LENGTH,
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [DATA_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_error
);

    localparam int DEPTH     = 2 ** ADDR_WIDTH;
    localparam int NUM_LANES = DATA_WIDTH / 8;
    localparam int CNT_W     = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);

    state_e                state;
    logic [CNT_W-1:0]      wait_cnt;
    logic                  lat_write;
    logic [1:0]            lat_size;
    logic                  lat_signed;
    logic [DATA_WIDTH-1:0] lat_addr;
    logic [DATA_WIDTH-1:0] lat_wdata;

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    // With WAIT_CYCLES = 0 the access commits on the acceptance edge, so
    // the live request is used in IDLE; otherwise the latched copy.
    logic                  acc_write;
    logic [1:0]            acc_size;
    logic                  acc_signed;
    logic [DATA_WIDTH-1:0] acc_addr;
    logic [DATA_WIDTH-1:0] acc_wdata;
    logic [ADDR_WIDTH-1:0] acc_idx;
    logic                  acc_err;
    logic [3:0]            acc_be;
    logic [DATA_WIDTH-1:0] store_data;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  enter_resp;
    logic                  do_write;

    always_comb begin
        if (state == IDLE) begin
            acc_write  = req_write;
            acc_size   = req_size;
            acc_signed = req_signed;
            acc_addr   = req_addr;
            acc_wdata  = req_wdata;
        end else begin
            acc_write  = lat_write;
            acc_size   = lat_size;
            acc_signed = lat_signed;
            acc_addr   = lat_addr;
            acc_wdata  = lat_wdata;
        end
        acc_idx = acc_addr[ADDR_WIDTH+1:2];
        acc_be  = lane_enable(acc_size, acc_addr[1:0]);
        acc_err = (acc_size == SIZE_ILL) ||
                  is_misaligned(acc_size, acc_addr[1:0]) ||
                  (|acc_addr[DATA_WIDTH-1:ADDR_WIDTH+2]);
        case (acc_size)
            SIZE_BYTE: store_data = {NUM_LANES{acc_wdata[7:0]}};
            SIZE_HALF: store_data = {(NUM_LANES/2){acc_wdata[15:0]}};
            default:   store_data = acc_wdata;
        endcase
        rd_word = mem[acc_idx];

        enter_resp = ((state == IDLE) && req_valid && req_ready && (WAIT_CYCLES == 0)) ||
                     ((state == WAIT) && (wait_cnt == CNT_W'(1)));
        // Gating with reset keeps a request held during reset from writing.
        do_write = reset && enter_resp && acc_write && !acc_err;
    end

    load_align #(.DATA_WIDTH(DATA_WIDTH)) u_load_align (
        .word     (rd_word),
        .addr_lo  (acc_addr[1:0]),
        .size     (acc_size),
        .sign_ext (acc_signed),
        .data     (load_data)
    );

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (acc_be[i]) begin
                    mem[acc_idx][8*i +: 8] <= store_data[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_error <= 1'b0;
            wait_cnt   <= '0;
            lat_write  <= 1'b0;
            lat_size   <= 2'b00;
            lat_signed <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
        end else begin
            if (enter_resp) begin
                state      <= RESP;
                resp_valid <= 1'b1;
                resp_error <= acc_err;
                resp_rdata <= (acc_write || acc_err) ? '0 : load_data;
            end
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        lat_write  <= req_write;
                        lat_size   <= req_size;
                        lat_signed <= req_signed;
                        lat_addr   <= req_addr;
                        lat_wdata  <= req_wdata;
                        req_ready  <= 1'b0;
                        if (WAIT_CYCLES != 0) begin
                            state    <= WAIT;
                            wait_cnt <= CNT_W'(WAIT_CYCLES);
                        end
                    end
                end
                WAIT: begin
                    wait_cnt <= wait_cnt - CNT_W'(1);
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        req_ready  <= 1'b1;
                        resp_valid <= 1'b0;
                        resp_rdata <= '0;
                        resp_error <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: one instance with WAIT_CYCLES = 2 (index 0)
// and one with WAIT_CYCLES = 0 (index 1), checked against a byte-addressed
// reference memory. Also exercises load_align on its own.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [1:0]  resp_valid;
    logic [1:0]  resp_ready = 2'b00;
    logic [31:0] resp_rdata [2];
    logic [1:0]  resp_error;

    logic [31:0] la_word = '0;
    logic [1:0]  la_lo = '0;
    logic [1:0]  la_size = '0;
    logic        la_sign = 1'b0;
    logic [31:0] la_data;

    int total = 0;
    int bad = 0;

    logic [7:0] mref [2][1024];

    always #5 clk = ~clk;

    data_mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .WAIT_CYCLES(2)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_rdata(resp_rdata[0]), .resp_error(resp_error[0])
    );

    data_mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .WAIT_CYCLES(0)) dut_w0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_rdata(resp_rdata[1]), .resp_error(resp_error[1])
    );

    load_align #(.DATA_WIDTH(32)) u_la (
        .word(la_word), .addr_lo(la_lo), .size(la_size), .sign_ext(la_sign), .data(la_data)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference: byte-addressed little-endian memory of 1 KiB per instance.
    task automatic model(input int d, input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] r, output logic e);
        int n;
        logic [31:0] v;
        e = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0) || (a >= 32'd1024);
        r = '0;
        if (e) return;
        n = 1 << sz;
        if (w) begin
            for (int i = 0; i < n; i++) mref[d][a+i] = wd[8*i +: 8];
        end else begin
            v = '0;
            for (int i = 0; i < n; i++) v[8*i +: 8] = mref[d][a+i];
            if (n < 4 && sg && v[8*n-1])
                for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
            r = v;
        end
    endtask

    task automatic do_req(input int d, input logic w, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd, input int hold,
                          output logic [31:0] got, output logic got_e);
        logic [31:0] er;
        logic ee;
        int edges;
        int lat;
        lat = (d == 0) ? 2 : 0;
        model(d, w, sz, sg, a, wd, er, ee);
        req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
        req_valid[d] = 1'b1;
        check("req_ready_idle", req_ready[d], 1);
        @(posedge clk); #1;
        req_valid[d] = 1'b0;
        edges = 0;
        while (!resp_valid[d] && edges < 20) begin
            @(posedge clk); #1;
            edges++;
        end
        check("latency", edges, lat);
        got   = resp_rdata[d];
        got_e = resp_error[d];
        check("rdata", got, er);
        check("error", got_e, ee);
        if (hold > 0) begin
            // A competing store to 0x10 must be ignored while busy.
            req_valid[d] = 1'b1; req_write = 1'b1; req_size = 2'd2;
            req_addr = 32'h10; req_wdata = $urandom;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                check("hold_valid", resp_valid[d], 1);
                check("hold_rdata", resp_rdata[d], er);
                check("hold_error", resp_error[d], ee);
                check("hold_ready", req_ready[d], 0);
            end
            req_valid[d] = 1'b0;
        end
        resp_ready[d] = 1'b1;
        @(posedge clk); #1;
        resp_ready[d] = 1'b0;
        check("done_valid", resp_valid[d], 0);
        check("done_ready", req_ready[d], 1);
        check("done_rdata", resp_rdata[d], 0);
    endtask

    function automatic logic [31:0] la_ref(input logic [31:0] wrd, input logic [1:0] lo,
                                           input logic [1:0] sz, input logic sg);
        int n;
        logic [31:0] v;
        if (sz == 2'd3) return '0;
        n = 1 << sz;
        v = '0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = wrd[8*(lo+i) +: 8];
        if (n < 4 && sg && v[8*n-1])
            for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
        return v;
    endfunction

    initial begin
        logic [31:0] g;
        logic        ge;
        logic        w;
        logic [1:0]  sz;
        logic [31:0] a;

        // Reset values while reset is held low.
        #12;
        for (int d = 0; d < 2; d++) begin
            check("rst_req_ready", req_ready[d], 1);
            check("rst_resp_valid", resp_valid[d], 0);
            check("rst_rdata", resp_rdata[d], 0);
            check("rst_error", resp_error[d], 0);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        // Known contents for the first 16 words of both instances.
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 16; i++)
                do_req(d, 1'b1, 2'd2, 1'b0, 32'(i * 4), $urandom, 0, g, ge);

        // Word store/load round trip.
        do_req(0, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 0, g, ge);
        check("t1_st_rdata", g, 32'h0);
        do_req(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, g, ge);
        check("t1_ld", g, 32'hDEADBEEF);
        check("t1_ld_err", ge, 0);

        // Extension of byte and half fields.
        do_req(0, 1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 0, g, ge);
        check("t2_sb", g, 32'hFFFFFFDE);
        do_req(0, 1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 0, g, ge);
        check("t2_ub", g, 32'h000000DE);
        do_req(0, 1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 0, g, ge);
        check("t2_sh", g, 32'hFFFFDEAD);
        do_req(0, 1'b0, 2'd1, 1'b0, 32'h10, 32'h0, 0, g, ge);
        check("t2_uh", g, 32'h0000BEEF);

        // Byte store into one lane.
        do_req(0, 1'b1, 2'd0, 1'b0, 32'h11, 32'h55, 0, g, ge);
        do_req(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, g, ge);
        check("t3_ld", g, 32'hDEAD55EF);

        // Error cases.
        do_req(0, 1'b1, 2'd2, 1'b0, 32'h12, 32'h12345678, 0, g, ge);
        check("t4_mis_err", ge, 1);
        check("t4_mis_rdata", g, 0);
        do_req(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, g, ge);
        check("t4_unchanged", g, 32'hDEAD55EF);
        do_req(0, 1'b0, 2'd3, 1'b0, 32'h10, 32'h0, 0, g, ge);
        check("t4_ill_size", ge, 1);
        do_req(0, 1'b0, 2'd2, 1'b0, 32'h400, 32'h0, 0, g, ge);
        check("t4_range", ge, 1);

        // Backpressure with a competing request.
        do_req(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 5, g, ge);
        check("t5_ld", g, 32'hDEAD55EF);
        do_req(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, g, ge);
        check("t5_stray_ignored", g, 32'hDEAD55EF);

        // Reset in WAIT discards a pending store.
        req_write = 1'b1; req_size = 2'd2; req_signed = 1'b0; req_addr = 32'h10; req_wdata = 32'h0;
        req_valid[0] = 1'b1;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("t6_rst_ready", req_ready[0], 1);
        check("t6_rst_valid", resp_valid[0], 0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("t6_post_valid", resp_valid[0], 0);
        do_req(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, g, ge);
        check("t6_ld", g, 32'hDEAD55EF);

        // Zero wait states.
        do_req(1, 1'b1, 2'd2, 1'b0, 32'h20, 32'hCAFEF00D, 0, g, ge);
        do_req(1, 1'b0, 2'd1, 1'b1, 32'h22, 32'h0, 0, g, ge);
        check("w0_sh", g, 32'hFFFFCAFE);

        // Randomized traffic on both instances.
        for (int d = 0; d < 2; d++) begin
            for (int n = 0; n < 150; n++) begin
                w  = 1'($urandom_range(0, 1));
                sz = 2'($urandom_range(0, 3));
                a  = 32'($urandom_range(0, 63));
                if ($urandom_range(0, 9) == 0) a = a | (32'h1 << $urandom_range(10, 31));
                do_req(d, w, sz, 1'($urandom_range(0, 1)), a, $urandom,
                       int'($urandom_range(0, 2)), g, ge);
            end
        end

        // load_align on its own, aligned combinations only.
        for (int n = 0; n < 40; n++) begin
            la_word = $urandom;
            la_size = 2'($urandom_range(0, 3));
            la_sign = 1'($urandom_range(0, 1));
            case (la_size)
                2'd0:    la_lo = 2'($urandom_range(0, 3));
                2'd1:    la_lo = {1'($urandom_range(0, 1)), 1'b0};
                default: la_lo = 2'd0;
            endcase
            #1;
            check("load_align", la_data, la_ref(la_word, la_lo, la_size, la_sign));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
